// File: rtl/rot_register_bank.sv
// rot_register_bank: parametrised register bank with two combinational read
// ports, one write port, a global one-bit rotate of every register, and a
// sequenced clear engine that walks the bank one register per cycle.
//
// state    | meaning
// ---------+-------------------------------------------------------------
// ST_IDLE  | accepting write / rotate / clear_start commands
// ST_CLEAR | zeroing reg[idx] each cycle, all commands ignored (busy = 1)

module rot_register_bank #(
  parameter int NUM_REGS = 16,
  parameter int DATA_W   = 4,
  parameter int ADDR_W   = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [ADDR_W-1:0] r1_addr,
  input  logic [ADDR_W-1:0] r2_addr,
  input  logic [ADDR_W-1:0] w_addr,
  input  logic [DATA_W-1:0] data_in,
  input  logic              set_data,
  input  logic              rot_en,
  input  logic              rot_dir,
  input  logic              clear_start,
  output logic              busy,
  output logic              clear_done,
  output logic [DATA_W-1:0] data_out1,
  output logic [DATA_W-1:0] data_out2
);

  typedef enum logic {
    ST_IDLE,
    ST_CLEAR
  } state_t;

  localparam logic [ADDR_W-1:0] LAST_IDX = ADDR_W'(NUM_REGS - 1);

  state_t                             state_q, state_d;
  logic [ADDR_W-1:0]                  idx_q, idx_d;
  logic                               busy_q, busy_d;
  logic                               done_q, done_d;
  logic [NUM_REGS-1:0][DATA_W-1:0]    regs_q, regs_d;

  // Clear sequencer next-state: clear_start wins over any other command in IDLE.
  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    busy_d  = busy_q;
    done_d  = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (clear_start) begin
          state_d = ST_CLEAR;
          idx_d   = '0;
          busy_d  = 1'b1;
        end
      end
      ST_CLEAR: begin
        if (idx_q == LAST_IDX) begin
          state_d = ST_IDLE;
          idx_d   = '0;
          busy_d  = 1'b0;
          done_d  = 1'b1;
        end else begin
          idx_d = idx_q + ADDR_W'(1);
        end
      end
    endcase
  end

  // Clear sequencer state and registered handshake outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      idx_q   <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  // Register next values: clear slot, or rotate-all with the write target
  // overriding its own rotated value. Out-of-range w_addr matches no register.
  always_comb begin
    regs_d = regs_q;
    if (state_q == ST_CLEAR) begin
      for (int i = 0; i < NUM_REGS; i++) begin
        if (idx_q == ADDR_W'(i)) regs_d[i] = '0;
      end
    end else if (!clear_start) begin
      for (int i = 0; i < NUM_REGS; i++) begin
        if (rot_en) begin
          if (rot_dir) regs_d[i] = {regs_q[i][0], regs_q[i][DATA_W-1:1]};
          else         regs_d[i] = {regs_q[i][DATA_W-2:0], regs_q[i][DATA_W-1]};
        end
        if (set_data && (w_addr == ADDR_W'(i))) regs_d[i] = data_in;
      end
    end
  end

  // Register storage.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) regs_q <= '0;
    else        regs_q <= regs_d;
  end

  // Combinational read ports; addresses beyond the bank read as zero.
  always_comb begin
    data_out1 = '0;
    data_out2 = '0;
    for (int i = 0; i < NUM_REGS; i++) begin
      if (r1_addr == ADDR_W'(i)) data_out1 = regs_q[i];
      if (r2_addr == ADDR_W'(i)) data_out2 = regs_q[i];
    end
  end

  assign busy       = busy_q;
  assign clear_done = done_q;

endmodule

// File: tb/tb_rot_register_bank.sv
// Bench for rot_register_bank: two instances (16x4 with 5-bit addresses and
// 5x8 with 3-bit addresses) checked every cycle against a behavioural model.

module tb_rot_register_bank;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  // instance A: NUM_REGS=16, DATA_W=4, ADDR_W=5
  logic [4:0] r1_a, r2_a, wa_a;
  logic [3:0] din_a;
  logic       sd_a, re_a, rd_a, cs_a;
  logic       busy_a, done_a;
  logic [3:0] q1_a, q2_a;

  // instance B: NUM_REGS=5, DATA_W=8, ADDR_W=3
  logic [2:0] r1_b, r2_b, wa_b;
  logic [7:0] din_b;
  logic       sd_b, re_b, rd_b, cs_b;
  logic       busy_b, done_b;
  logic [7:0] q1_b, q2_b;

  rot_register_bank #(.NUM_REGS(16), .DATA_W(4), .ADDR_W(5)) dut_a (
    .clk(clk), .rst_n(rst_n), .r1_addr(r1_a), .r2_addr(r2_a), .w_addr(wa_a),
    .data_in(din_a), .set_data(sd_a), .rot_en(re_a), .rot_dir(rd_a),
    .clear_start(cs_a), .busy(busy_a), .clear_done(done_a),
    .data_out1(q1_a), .data_out2(q2_a)
  );

  rot_register_bank #(.NUM_REGS(5), .DATA_W(8), .ADDR_W(3)) dut_b (
    .clk(clk), .rst_n(rst_n), .r1_addr(r1_b), .r2_addr(r2_b), .w_addr(wa_b),
    .data_in(din_b), .set_data(sd_b), .rot_en(re_b), .rot_dir(rd_b),
    .clear_start(cs_b), .busy(busy_b), .clear_done(done_b),
    .data_out1(q1_b), .data_out2(q2_b)
  );

  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s actual=%0h required=%0h t=%0t", nm, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  logic [7:0] mm [2][16];
  int         left [2];
  int         cidx [2];
  bit         dexp [2];

  function automatic logic [7:0] rotv(input logic [7:0] v, input int w, input logic dir);
    int mask = (1 << w) - 1;
    int x = int'(v);
    if (!dir) return 8'(((x << 1) | (x >> (w - 1))) & mask);
    else      return 8'(((x >> 1) | (x << (w - 1))) & mask);
  endfunction

  function automatic logic [7:0] exp_rd(input int k, input int n, input int a);
    return (a < n) ? mm[k][a] : 8'h00;
  endfunction

  task automatic model_reset();
    for (int k = 0; k < 2; k++) begin
      for (int i = 0; i < 16; i++) mm[k][i] = 8'h00;
      left[k] = 0;
      cidx[k] = 0;
      dexp[k] = 1'b0;
    end
  endtask

  task automatic model_step(input int k, input int n, input int w, input logic cs,
                            input logic sd, input logic re, input logic rd,
                            input int wa, input logic [7:0] din);
    dexp[k] = 1'b0;
    if (left[k] > 0) begin
      mm[k][cidx[k]] = 8'h00;
      cidx[k]++;
      left[k]--;
      if (left[k] == 0) dexp[k] = 1'b1;
    end else if (cs) begin
      left[k] = n;
      cidx[k] = 0;
    end else begin
      if (re) for (int i = 0; i < n; i++) mm[k][i] = rotv(mm[k][i], w, rd);
      if (sd && wa < n) mm[k][wa] = din;
    end
  endtask

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) model_reset();
    else begin
      model_step(0, 16, 4, cs_a, sd_a, re_a, rd_a, int'(wa_a), {4'h0, din_a});
      model_step(1, 5, 8, cs_b, sd_b, re_b, rd_b, int'(wa_b), din_b);
    end
  end

  // per-cycle compare, away from the active edge
  always @(negedge clk) begin
    chk("a_busy", 32'(busy_a), 32'(left[0] > 0));
    chk("a_done", 32'(done_a), 32'(dexp[0]));
    chk("a_rd1",  32'(q1_a),   32'(exp_rd(0, 16, int'(r1_a))));
    chk("a_rd2",  32'(q2_a),   32'(exp_rd(0, 16, int'(r2_a))));
    chk("b_busy", 32'(busy_b), 32'(left[1] > 0));
    chk("b_done", 32'(done_b), 32'(dexp[1]));
    chk("b_rd1",  32'(q1_b),   32'(exp_rd(1, 5, int'(r1_b))));
    chk("b_rd2",  32'(q2_b),   32'(exp_rd(1, 5, int'(r2_b))));
  end

  // ---------------- stimulus helpers ----------------
  task automatic cyc();
    @(posedge clk);
    #2;
    cs_a = 1'b0; sd_a = 1'b0; re_a = 1'b0;
    cs_b = 1'b0; sd_b = 1'b0; re_b = 1'b0;
  endtask

  task automatic wr_a(input logic [4:0] a, input logic [3:0] d);
    wa_a = a; din_a = d; sd_a = 1'b1; cyc();
  endtask

  task automatic wr_b(input logic [2:0] a, input logic [7:0] d);
    wa_b = a; din_b = d; sd_b = 1'b1; cyc();
  endtask

  task automatic rot_a(input logic dir);
    re_a = 1'b1; rd_a = dir; cyc();
  endtask

  task automatic rot_b(input logic dir);
    re_b = 1'b1; rd_b = dir; cyc();
  endtask

  task automatic lit_a(input logic [4:0] a, input logic [3:0] e, input string nm);
    r1_a = a;
    @(negedge clk);
    chk(nm, 32'(q1_a), 32'(e));
    @(posedge clk); #2;
  endtask

  task automatic lit_b(input logic [2:0] a, input logic [7:0] e, input string nm);
    r1_b = a;
    @(negedge clk);
    chk(nm, 32'(q1_b), 32'(e));
    @(posedge clk); #2;
  endtask

  task automatic sweep_a();
    for (int i = 0; i < 32; i += 2) begin
      r1_a = 5'(i); r2_a = 5'(i + 1); cyc();
    end
  endtask

  task automatic sweep_b();
    for (int i = 0; i < 8; i += 2) begin
      r1_b = 3'(i); r2_b = 3'(i + 1); cyc();
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog expired t=%0t", $time);
    $fatal(1);
  end

  int nb, nd;

  initial begin
    rst_n = 1'b1;
    r1_a = '0; r2_a = '0; wa_a = '0; din_a = '0;
    sd_a = 1'b0; re_a = 1'b0; rd_a = 1'b0; cs_a = 1'b0;
    r1_b = '0; r2_b = '0; wa_b = '0; din_b = '0;
    sd_b = 1'b0; re_b = 1'b0; rd_b = 1'b0; cs_b = 1'b0;
    #1 rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #2 rst_n = 1'b1;

    // reset state
    @(negedge clk);
    chk("a_rst_busy", 32'(busy_a), 32'h0);
    chk("a_rst_done", 32'(done_a), 32'h0);
    @(posedge clk); #2;
    lit_a(5'd17, 4'h0, "a_rst_addr17");
    sweep_a();
    sweep_b();

    // rotate left / right
    wr_a(5'd3, 4'h9);
    rot_a(1'b0);
    lit_a(5'd3, 4'h3, "a_rotl_9");
    rot_a(1'b1);
    lit_a(5'd3, 4'h9, "a_rotr_3");

    // write + rotate same cycle
    wr_a(5'd5, 4'h1);
    wr_a(5'd6, 4'h8);
    wa_a = 5'd5; din_a = 4'hA; sd_a = 1'b1; re_a = 1'b1; rd_a = 1'b0;
    cyc();
    lit_a(5'd5, 4'hA, "a_wr_rot_target");
    lit_a(5'd6, 4'h1, "a_wr_rot_other");
    sweep_a();

    // full clear on instance A
    for (int i = 0; i < 16; i++) wr_a(5'(i), 4'hF);
    r1_a = 5'd3; r2_a = 5'd4;
    cs_a = 1'b1;
    cyc();
    nb = 0; nd = 0;
    for (int k = 1; k <= 40; k++) begin
      @(negedge clk);
      if (busy_a) nb++;
      if (done_a) nd++;
      if (k == 5) begin
        chk("a_mid_reg3", 32'(q1_a), 32'h0);
        chk("a_mid_reg4", 32'(q2_a), 32'hF);
      end
      if (k == 3) begin wa_a = 5'd0; din_a = 4'h5; sd_a = 1'b1; end
      if (k == 4) sd_a = 1'b0;
      if (k == 6) cs_a = 1'b1;
      if (k == 7) cs_a = 1'b0;
      if (nd > 0 && !done_a) break;
    end
    chk("a_clr_busy_cycles", 32'(nb), 32'd16);
    chk("a_clr_done_pulses", 32'(nd), 32'd1);
    @(posedge clk); #2;
    lit_a(5'd0, 4'h0, "a_busy_write_blocked");
    sweep_a();

    // asynchronous reset in the middle of a clear
    wr_a(5'd10, 4'h7);
    r1_a = 5'd10;
    cs_a = 1'b1;
    cyc();
    repeat (4) @(posedge clk);
    #3 rst_n = 1'b0;
    #1;
    chk("a_async_busy", 32'(busy_a), 32'h0);
    chk("a_async_reg10", 32'(q1_a), 32'h0);
    chk("a_async_done", 32'(done_a), 32'h0);
    @(posedge clk);
    @(posedge clk);
    #2 rst_n = 1'b1;
    nd = 0;
    repeat (20) begin
      @(negedge clk);
      if (done_a) nd++;
    end
    chk("a_async_no_done", 32'(nd), 32'd0);
    @(posedge clk); #2;
    sweep_a();

    // instance B: 8-bit rotate, out-of-range write
    wr_b(3'd0, 8'h81);
    rot_b(1'b0);
    lit_b(3'd0, 8'h03, "b_rotl_81");
    rot_b(1'b1);
    lit_b(3'd0, 8'h81, "b_rotr_03");
    wr_b(3'd4, 8'hC3);
    wr_b(3'd7, 8'h55);
    lit_b(3'd7, 8'h00, "b_oor_read");
    lit_b(3'd4, 8'hC3, "b_reg4_kept");
    sweep_b();

    // clear_start priority, back-to-back clear on the done cycle
    wr_b(3'd1, 8'h11);
    r1_b = 3'd1;
    wa_b = 3'd1; din_b = 8'h66; sd_b = 1'b1; re_b = 1'b1; rd_b = 1'b0; cs_b = 1'b1;
    cyc();
    nb = 0; nd = 0;
    for (int k = 1; k <= 40; k++) begin
      @(negedge clk);
      if (busy_b) nb++;
      if (k == 1) chk("b_prio_reg1", 32'(q1_b), 32'h11);
      if (done_b) begin
        nd++;
        if (nd == 1) cs_b = 1'b1;
      end else begin
        cs_b = 1'b0;
      end
      if (nd == 2 && !done_b) break;
    end
    chk("b_clr_busy_cycles", 32'(nb), 32'd10);
    chk("b_clr_done_pulses", 32'(nd), 32'd2);
    @(posedge clk); #2;
    sweep_b();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/rot_register_bank.md
Name: rot_register_bank

Overview:
- Parametrised successor to the baby_vga 16x4 rotating register file.
- Register count and data width are parameters.
- Adds:
  - global rotate (left or right by one bit) applied to all registers
  - sequenced clear engine with busy/done handshake
  - defined behaviour for out-of-range addresses
- Sits between the peripheral register interface (writes, rotate and clear commands) and the pixel/pattern logic, which consumes the two combinational read ports.

Parameters:
- NUM_REGS, 16, number of registers; 2..256.
- DATA_W, 4, bits per register; >= 2.
- ADDR_W, 4, address width; must satisfy 2**ADDR_W >= NUM_REGS.

Ports:
- clk  input  1  system clock, rising edge.
- rst_n  input  1  asynchronous active-low reset.
- r1_addr  input  ADDR_W  read port 1 address.
- r2_addr  input  ADDR_W  read port 2 address.
- w_addr  input  ADDR_W  write address.
- data_in  input  DATA_W  write data.
- set_data  input  1  write strobe, one register per asserted cycle.
- rot_en  input  1  rotate all registers by one bit this cycle.
- rot_dir  input  1  0 = rotate left (MSB to LSB position), 1 = rotate right (LSB to MSB position).
- clear_start  input  1  begin sequenced clear of all registers.
- busy  output  1  high while the clear engine is running.
- clear_done  output  1  one-cycle pulse on the cycle after the last register is cleared.
- data_out1  output  DATA_W  contents of register r1_addr.
- data_out2  output  DATA_W  contents of register r2_addr.

Behaviour:
- Reset (rst_n low, asynchronous): all registers = 0, FSM = IDLE, clear index = 0, busy = 0, clear_done = 0. Reset mid-clear aborts the clear with the same result.
- Reads:
  - Purely combinational, zero latency.
  - Address >= NUM_REGS returns 0.
  - A write or rotate becomes visible on the read ports the cycle after the edge that commits it; there is no write-through bypass.
- Write: when set_data=1 and busy=0, reg[w_addr] <= data_in at the edge. w_addr >= NUM_REGS is a no-op.
- Rotate: when rot_en=1 and busy=0, every register updates at the edge.
  - rot_dir=0 (left): reg <= {reg[DATA_W-2:0], reg[DATA_W-1]}
  - rot_dir=1 (right): reg <= {reg[0], reg[DATA_W-1:1]}
- Write and rotate in the same cycle: the addressed register takes data_in unrotated; all other registers rotate.
- FSM states:
  - IDLE:
    - On clear_start=1: go to CLEAR, index = 0, busy = 1 from the next cycle.
    - clear_start has priority: set_data and rot_en in the same cycle are ignored.
  - CLEAR:
    - Each cycle reg[index] <= 0 and index increments.
    - When index == NUM_REGS-1: that register is cleared, FSM returns to IDLE, busy drops, clear_done pulses high for exactly one cycle (the first IDLE cycle).
    - A full clear takes NUM_REGS cycles of busy.
- While busy=1, set_data, rot_en and clear_start are ignored. No command is queued.
- Registers not yet reached by the clear index keep their values and remain readable. Registers already cleared read 0.
- A clear_start asserted on the same cycle clear_done is high is accepted as a new clear.
- Index arithmetic is ADDR_W bits and never wraps past NUM_REGS-1.

Test Plan:
- Reset then read all addresses -> every read returns 0, busy=0, clear_done=0. Read address 17 with NUM_REGS=16, ADDR_W=5 -> 0.
- Write 0x9 to reg 3, rot_en=1 rot_dir=0 for one cycle -> reg 3 reads 0x3. Then rot_dir=1 -> reads 0x9.
- Load reg 5 = 0x1 and reg 6 = 0x8. In the same cycle, set_data (w_addr=5, data_in=0xA) with rot_en=1 rot_dir=0 -> reg 5 = 0xA, reg 6 = 0x1.
- Fill regs 0..15 with 0xF, pulse clear_start:
  - busy=1 for exactly 16 cycles
  - mid-clear (after 4 busy cycles) reg 3 = 0 and reg 4 = 0xF
  - clear_done pulses once
  - all registers read 0
  - a set_data issued while busy leaves its target at the cleared value
- Drop rst_n asynchronously (between clock edges) in the middle of a clear -> busy falls immediately, all registers read 0, no clear_done pulse.
- Repeat the rotate and clear scenarios with NUM_REGS=5, DATA_W=8:
  - rotate 0x81 left -> 0x03
  - clear takes 5 cycles
  - write to w_addr=7 is ignored
